// File: rtl/machine_pkg.sv
// Shared opcode, state and strobe-bundle definitions for the instruction-sequencing controller.
package machine_pkg;

  localparam logic [2:0] HLT = 3'b000;
  localparam logic [2:0] SKZ = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] AND = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] LDA = 3'b101;
  localparam logic [2:0] STO = 3'b110;
  localparam logic [2:0] JMP = 3'b111;

  localparam logic [3:0] F0     = 4'd0;
  localparam logic [3:0] F1     = 4'd1;
  localparam logic [3:0] F2     = 4'd2;
  localparam logic [3:0] F3     = 4'd3;
  localparam logic [3:0] IDLE   = 4'd4;
  localparam logic [3:0] SETUP  = 4'd5;
  localparam logic [3:0] EXA    = 4'd6;
  localparam logic [3:0] EXB    = 4'd7;
  localparam logic [3:0] EXC    = 4'd8;
  localparam logic [3:0] SKIP   = 4'd9;
  localparam logic [3:0] EXD    = 4'd10;
  localparam logic [3:0] HALTED = 4'd11;

  typedef struct packed {
    logic inc_pc;
    logic load_acc;
    logic load_pc;
    logic rd;
    logic wr;
    logic load_ir;
    logic halt;
    logic datactl_ena;
  } strobe_t;

  function automatic logic is_fetch(input logic [3:0] s);
    return s[3:2] == 2'b00;
  endfunction

endpackage

// File: rtl/machine_decode.sv
// Combinational state/opcode decode to the datapath strobe bundle.
import machine_pkg::*;

module machine_decode #(
  parameter int unsigned OPW = 3
) (
  input  logic [3:0]     state,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  output strobe_t        strobe
);

  logic       is_nop;
  logic [2:0] op;
  logic       mem_op;
  logic       is_sto;
  logic       is_jmp;
  logic       is_skz;
  logic       is_hlt;

  // Opcodes wider than three bits with any upper bit set are treated as NOP.
  generate
    if (OPW > 3) begin : g_wide
      assign is_nop = |opcode[OPW-1:3];
    end else begin : g_narrow
      assign is_nop = 1'b0;
    end
  endgenerate

  assign op     = opcode[2:0];
  assign mem_op = !is_nop && (op == ADD || op == AND || op == XOR || op == LDA);
  assign is_sto = !is_nop && (op == STO);
  assign is_jmp = !is_nop && (op == JMP);
  assign is_skz = !is_nop && (op == SKZ);
  assign is_hlt = !is_nop && (op == HLT);

  always_comb begin
    strobe = '0;
    case (state)
      F0, F1, F2, F3: begin
        strobe.rd      = 1'b1;
        strobe.load_ir = 1'b1;
        strobe.inc_pc  = (state != F0);
      end
      SETUP: begin
        if (is_hlt) strobe.halt   = 1'b1;
        else        strobe.inc_pc = 1'b1;
      end
      EXA: begin
        strobe.rd          = mem_op;
        strobe.datactl_ena = is_sto;
        strobe.load_pc     = is_jmp;
      end
      EXB: begin
        strobe.rd          = mem_op;
        strobe.load_acc    = mem_op;
        strobe.wr          = is_sto;
        strobe.datactl_ena = is_sto;
        strobe.load_pc     = is_jmp;
      end
      EXC: begin
        strobe.datactl_ena = is_sto;
        strobe.inc_pc      = is_skz && zero;
      end
      SKIP:    strobe.inc_pc = 1'b1;
      HALTED:  strobe.halt   = 1'b1;
      default: strobe = '0;
    endcase
  end

endmodule

// File: rtl/machine_ctl_p.sv
// Parametrised falling-edge instruction sequencer: multi-word fetch, wait states, skip and sticky halt.
import machine_pkg::*;

module machine_ctl_p #(
  parameter int unsigned OPW         = 3,
  parameter int unsigned FETCH_WORDS = 2,
  parameter int unsigned WAIT_EN     = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ready,
  input  logic           resume,
  output logic           inc_pc,
  output logic           load_acc,
  output logic           load_pc,
  output logic           rd,
  output logic           wr,
  output logic           load_ir,
  output logic [1:0]     fetch_idx,
  output logic           halt,
  output logic           datactl_ena,
  output logic [3:0]     state_o
);

  localparam logic [3:0]  F_LAST      = 4'(FETCH_WORDS - 1);
  localparam int unsigned SKIP_LOAD_I = (FETCH_WORDS > 1) ? FETCH_WORDS - 2 : 0;
  localparam logic [1:0]  SKIP_LOAD   = SKIP_LOAD_I[1:0];

  logic [3:0] state_q, state_d;
  logic [1:0] skip_cnt_q, skip_cnt_d;
  logic [1:0] fetch_idx_q, fetch_idx_d;
  strobe_t    strobe_q, strobe_d;
  strobe_t    dec;
  logic       stall;

  machine_decode #(.OPW(OPW)) u_decode (
    .state  (state_q),
    .opcode (opcode),
    .zero   (zero),
    .strobe (dec)
  );

  always_comb begin
    state_d     = state_q;
    skip_cnt_d  = skip_cnt_q;
    strobe_d    = dec;
    fetch_idx_d = is_fetch(state_q) ? state_q[1:0] : 2'b00;
    stall       = (WAIT_EN != 0) && (dec.rd || dec.wr) && !mem_ready;

    case (state_q)
      F0, F1, F2, F3: state_d = (state_q == F_LAST) ? IDLE : state_q + 4'd1;
      IDLE:           state_d = SETUP;
      SETUP:          state_d = dec.halt ? HALTED : EXA;
      EXA:            state_d = EXB;
      EXB:            state_d = EXC;
      // A taken SKZ is the only EXC case that raises inc_pc.
      EXC: begin
        if (dec.inc_pc) begin
          state_d    = (FETCH_WORDS > 1) ? SKIP : EXD;
          skip_cnt_d = SKIP_LOAD;
        end else begin
          state_d = EXD;
        end
      end
      SKIP: begin
        if (skip_cnt_q == 2'd0) state_d = EXD;
        else                    skip_cnt_d = skip_cnt_q - 2'd1;
      end
      EXD:            state_d = F0;
      HALTED: begin
        if (resume) begin
          state_d  = F0;
          strobe_d = '0;
        end
      end
      default: begin
        state_d  = F0;
        strobe_d = '0;
      end
    endcase

    // Memory not ready: repeat the bus cycle but suppress one-shot strobes.
    if (stall) begin
      state_d           = state_q;
      skip_cnt_d        = skip_cnt_q;
      strobe_d.inc_pc   = 1'b0;
      strobe_d.load_pc  = 1'b0;
      strobe_d.load_acc = 1'b0;
    end

    if (!ena) begin
      state_d     = F0;
      skip_cnt_d  = '0;
      strobe_d    = '0;
      fetch_idx_d = '0;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= F0;
      skip_cnt_q  <= '0;
      strobe_q    <= '0;
      fetch_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      skip_cnt_q  <= skip_cnt_d;
      strobe_q    <= strobe_d;
      fetch_idx_q <= fetch_idx_d;
    end
  end

  assign inc_pc      = strobe_q.inc_pc;
  assign load_acc    = strobe_q.load_acc;
  assign load_pc     = strobe_q.load_pc;
  assign rd          = strobe_q.rd;
  assign wr          = strobe_q.wr;
  assign load_ir     = strobe_q.load_ir;
  assign halt        = strobe_q.halt;
  assign datactl_ena = strobe_q.datactl_ena;
  assign fetch_idx   = fetch_idx_q;
  assign state_o     = state_q;

endmodule

// File: doc/machine_ctl_p.md
Name: machine_ctl_p

Overview:
Parametrised instruction-sequencing controller for the RISC CPU. It is the successor of the fixed 8-state control machine. It fetches an instruction of FETCH_WORDS bus words, decodes the opcode, and emits the datapath strobes that drive pc, acc, ir, datactl and the memory rd/wr lines. New behaviour over the fixed machine: configurable fetch length, memory wait-state handshake, skip of a full multi-word instruction, and a sticky halt released by resume.

Parameters:
OPW, 3, opcode width; codes at or above 8 decode as NOP.
FETCH_WORDS, 2, bus words per instruction, legal range 1..4.
WAIT_EN, 1, 1 = honour mem_ready on rd/wr cycles; 0 = ignore mem_ready.

Ports:
clk  in  1  system clock; FSM and outputs update on the falling edge
rst_n  in  1  asynchronous active-low reset
ena  in  1  synchronous run enable; low forces restart
opcode  in  OPW  opcode field from ir
zero  in  1  accumulator-zero flag
mem_ready  in  1  memory has completed the current rd/wr
resume  in  1  leave HALTED state
inc_pc  out  1  pc increment strobe
load_acc  out  1  acc load strobe
load_pc  out  1  pc load strobe (jump)
rd  out  1  memory read
wr  out  1  memory write
load_ir  out  1  ir load strobe
fetch_idx  out  2  ir word slot written when load_ir=1
halt  out  1  halted indicator
datactl_ena  out  1  drive acc onto data bus
state_o  out  4  current state encoding (debug)

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state = F0 (fetch word 0).
  - All outputs 0, fetch_idx = 0, state_o = F0 code.
- ena=0 at a falling edge: same result as reset, applied synchronously.
- Output timing: at each falling edge with ena=1, outputs <= decode(current state), then state <= next.
- Fetch states F0..F(FW-1), where k is the word index:
  - rd=1, load_ir=1, fetch_idx=k.
  - inc_pc=1 for k>0 only.
- IDLE: all outputs 0.
- SETUP:
  - HLT: halt=1, next state HALTED.
  - Any other opcode: inc_pc=1, next state EXA.
- EXA:
  - ADD/AND/XOR/LDA: rd=1.
  - STO: datactl_ena=1.
  - JMP: load_pc=1.
  - SKZ and NOP: all outputs 0.
- EXB:
  - ADD/AND/XOR/LDA: rd=1, load_acc=1.
  - STO: wr=1, datactl_ena=1.
  - JMP: load_pc=1.
  - Others: all outputs 0.
- EXC:
  - STO: datactl_ena=1.
  - SKZ with zero=1: inc_pc=1. Next state is SKIP if FW>1, otherwise EXD.
  - Others: all outputs 0.
- SKIP: inc_pc=1 on each of FW-1 consecutive edges (internal counter), then EXD.
- EXD: all outputs 0; next state F0.
- Cycle counts: a non-halt instruction takes FW+6 edges; a taken SKZ takes an extra FW-1 edges.
- HALTED:
  - halt held at 1, all other outputs 0.
  - resume=1 at a falling edge: halt <= 0, next state F0.
  - ena=0 overrides resume.
- Wait states (WAIT_EN=1):
  - Applies to any state whose decode has rd or wr set.
  - If mem_ready=0 at the edge, state is held and rd/wr/load_ir/fetch_idx/datactl_ena are held.
  - inc_pc, load_pc and load_acc are forced to 0 during the hold. Each is asserted exactly once, on the edge where mem_ready=1.
- zero is sampled only at EXC. opcode is sampled at SETUP, EXA, EXB and EXC; ir is stable over that window.
- rst_n asserted mid-instruction aborts it at once; no strobe completes.

Decomposition:
- Package machine_pkg holds:
  - opcode localparams HLT..JMP (3'b000..3'b111);
  - 4-bit state codes F0..F3, IDLE, SETUP, EXA, EXB, EXC, SKIP, EXD, HALTED;
  - the strobe-bundle ordering {inc_pc, load_acc, load_pc, rd, wr, load_ir, halt, datactl_ena}.
- One sub-module, machine_decode: combinational (state, opcode, zero) -> strobe bundle. It is shared with a future microcode-ROM variant.

Test Plan:
1. FW=2, LDA then STO, mem_ready=1:
   - LDA: 8 edges; rd high on F0/F1/EXA/EXB; load_acc only on EXB; inc_pc on F1 and SETUP.
   - STO: wr only on EXB; datactl_ena on EXA..EXC.
2. FW=2, SKZ with zero=1: inc_pc on F1, SETUP, EXC and one SKIP edge, 4 pulses total; with zero=0, 2 pulses and 8 edges.
3. HLT: halt rises after SETUP and stays 1 for 10 edges with resume=0. Pulse resume for one edge: halt falls and state_o = F0 next.
4. WAIT_EN=1, mem_ready low for 3 edges during F1: state_o held at F1, rd/load_ir held, inc_pc asserted exactly once (when mem_ready=1).
5. rst_n pulsed low mid-EXB of STO: wr/datactl_ena drop immediately, state_o = F0. ena low at EXA: same result at the next falling edge.
6. FW=1 and FW=4, ADD: instruction length 7 and 10 edges; fetch_idx sequences 0 and 0,1,2,3.
